alu_sequencer: RTL and testbench

Issue/writeback controller on the driving side of the 8-bit ALU. Accepts one instruction per handshake and reads operands from an internal register file. Presents opcode and operands to the ALU, then captures the ALU result into the register file and latches the greater/equal flags. Sits between the instruction decoder and the combinational ALU; the latched flags feed branch logic.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_regfile.sv | 45 ++++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, state encoding and default sizes for alu_sequencer
//
// Purpose : common definitions imported by alu_seq_regfile and alu_sequencer.
// Contents: OP_AND..OP_SUB opcode constants, state_e (ST_IDLE/ST_EXEC/ST_DONE),
//           REGS_DEF / RA_W_DEF default register-file geometry.
package alu_seq_pkg;

  localparam int REGS_DEF = 8;
  localparam int RA_W_DEF = 3;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - REGS x 8 register file, r0 hardwired to zero
//
// Purpose : operand storage for alu_sequencer.
// Ports   : clk_i, rst_n_i (sync active-low clear of all entries)
//           we_i/waddr_i/wdata_i   synchronous write port (writes to r0 discarded)
//           raddr_a_i/rdata_a_o    combinational read port A
//           raddr_b_i/rdata_b_o    combinational read port B
//           dbg_addr_i/dbg_data_o  combinational debug read port
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int REGS = REGS_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            we_i,
  input  logic [RA_W-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [RA_W-1:0] raddr_a_i,
  output logic [7:0]      rdata_a_o,
  input  logic [RA_W-1:0] raddr_b_i,
  output logic [7:0]      rdata_b_o,
  input  logic [RA_W-1:0] dbg_addr_i,
  output logic [7:0]      dbg_data_o
);

  logic [7:0] mem_q [REGS];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REGS; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced to zero on read as well, so it never depends on mem_q[0].
  assign rdata_a_o  = (raddr_a_i  == '0) ? 8'h00 : mem_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? 8'h00 : mem_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? 8'h00 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue/writeback controller driving an external 8-bit ALU
//
// Purpose : accepts one instruction per handshake, reads operands from the
//           register file, presents them to the ALU for one cycle, writes the
//           result back and latches the compare flags on SUB.
// Config  : ALU_SEQ_IMM_EN - when defined, instr_imm_en_i selects instr_imm_i
//           as operand B; otherwise B is always rf[rb] and the imm ports are ignored.
// Ports   : clk_i, rst_n_i (sync active-low)
//           instr_valid_i/instr_ready_o, instr_op_i, instr_rd_i, instr_ra_i,
//           instr_rb_i, instr_imm_en_i, instr_imm_i  - instruction handshake
//           alu_opcode_o, alu_a_o, alu_b_o           - registered ALU inputs
//           alu_result_i, alu_gr_i, alu_eq_i         - ALU outputs
//           flg_gr_o, flg_eq_o                       - flags latched by last SUB
//           done_o                                   - writeback committed pulse
//           dbg_addr_i/dbg_data_o                    - register-file debug read
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REGS = REGS_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [2:0]      instr_op_i,
  input  logic [RA_W-1:0] instr_rd_i,
  input  logic [RA_W-1:0] instr_ra_i,
  input  logic [RA_W-1:0] instr_rb_i,
  input  logic            instr_imm_en_i,
  input  logic [7:0]      instr_imm_i,
  output logic [2:0]      alu_opcode_o,
  output logic [7:0]      alu_a_o,
  output logic [7:0]      alu_b_o,
  input  logic [7:0]      alu_result_i,
  input  logic            alu_gr_i,
  input  logic            alu_eq_i,
  output logic            flg_gr_o,
  output logic            flg_eq_o,
  output logic            done_o,
  input  logic [RA_W-1:0] dbg_addr_i,
  output logic [7:0]      dbg_data_o
);

  state_e          state_q;
  logic [2:0]      op_q;
  logic [RA_W-1:0] rd_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [7:0]      b_d;
  logic            flg_gr_q;
  logic            flg_eq_q;
  logic            done_q;
  logic [7:0]      rdata_a;
  logic [7:0]      rdata_b;
  logic            rf_we;

  // Writeback happens on the edge that closes EXEC. A reset on that same edge
  // wins inside the register file, which cancels the pending write.
  assign rf_we = (state_q == ST_EXEC);

  alu_seq_regfile #(
    .REGS (REGS),
    .RA_W (RA_W)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (alu_result_i),
    .raddr_a_i  (instr_ra_i),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (instr_rb_i),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

`ifdef ALU_SEQ_IMM_EN
  assign b_d = instr_imm_en_i ? instr_imm_i : rdata_b;
`else
  logic unused_imm;
  assign unused_imm = ^{instr_imm_en_i, instr_imm_i};
  assign b_d        = rdata_b;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      rd_q     <= '0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      flg_gr_q <= 1'b0;
      flg_eq_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // Ready is implied here: we are in IDLE and out of reset.
          if (instr_valid_i) begin
            op_q    <= instr_op_i;
            rd_q    <= instr_rd_i;
            a_q     <= rdata_a;
            b_q     <= b_d;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_SUB) begin
            flg_gr_q <= alu_gr_i;
            flg_eq_q <= alu_eq_i;
          end
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready_o = (state_q == ST_IDLE) & rst_n_i;
  assign alu_opcode_o  = op_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign flg_gr_o      = flg_gr_q;
  assign flg_eq_o      = flg_eq_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [2:0] instr_rd;
  logic [2:0] instr_ra;
  logic [2:0] instr_rb;
  logic       instr_imm_en;
  logic [7:0] instr_imm;
  logic [2:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       alu_gr;
  logic       alu_eq;
  logic       flg_gr;
  logic       flg_eq;
  logic       done;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exec_op;
  logic [7:0] exec_a;
  logic [7:0] exec_b;
  int         acc_cnt;
  int         done_cnt;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .instr_valid_i  (instr_valid),
    .instr_ready_o  (instr_ready),
    .instr_op_i     (instr_op),
    .instr_rd_i     (instr_rd),
    .instr_ra_i     (instr_ra),
    .instr_rb_i     (instr_rb),
    .instr_imm_en_i (instr_imm_en),
    .instr_imm_i    (instr_imm),
    .alu_opcode_o   (alu_opcode),
    .alu_a_o        (alu_a),
    .alu_b_o        (alu_b),
    .alu_result_i   (alu_result),
    .alu_gr_i       (alu_gr),
    .alu_eq_i       (alu_eq),
    .flg_gr_o       (flg_gr),
    .flg_eq_o       (flg_eq),
    .done_o         (done),
    .dbg_addr_i     (dbg_addr),
    .dbg_data_o     (dbg_data)
  );

  // Reference 8-bit combinational ALU standing in for the external block.
  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = ~(alu_a & alu_b);
      3'b010: alu_result = alu_a | alu_b;
      3'b011: alu_result = ~(alu_a | alu_b);
      3'b100: alu_result = alu_a ^ alu_b;
      3'b101: alu_result = ~(alu_a ^ alu_b);
      3'b110: alu_result = alu_a + alu_b;
      3'b111: alu_result = alu_a - alu_b;
      default: alu_result = 8'h00;
    endcase
  end
  assign alu_gr = (alu_a > alu_b);
  assign alu_eq = (alu_a == alu_b);

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic rf_check(input string tag, input logic [2:0] addr, input logic [7:0] expected);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, expected);
  endtask

  // Issues one instruction from IDLE and checks the 3-cycle handshake timing.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic imm_en, input logic [7:0] imm);
    check({tag, "_ready_idle"}, {7'b0, instr_ready}, 8'h01);
    instr_op     = op;
    instr_rd     = rd;
    instr_ra     = ra;
    instr_rb     = rb;
    instr_imm_en = imm_en;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    @(posedge clk); #1;
    instr_valid  = 1'b0;
    instr_op     = 3'b000;
    instr_ra     = 3'd7;
    instr_rb     = 3'd7;
    exec_op = alu_opcode;
    exec_a  = alu_a;
    exec_b  = alu_b;
    check({tag, "_exec_ready"}, {7'b0, instr_ready}, 8'h00);
    check({tag, "_exec_done"},  {7'b0, done}, 8'h00);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {7'b0, done}, 8'h01);
    check({tag, "_done_ready"}, {7'b0, instr_ready}, 8'h00);
    @(posedge clk); #1;
    check({tag, "_done_clear"}, {7'b0, done}, 8'h00);
  endtask

  initial begin
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_op     = 3'b000;
    instr_rd     = 3'd0;
    instr_ra     = 3'd0;
    instr_rb     = 3'd0;
    instr_imm_en = 1'b0;
    instr_imm    = 8'h00;
    dbg_addr     = 3'd0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ready_in_reset", {7'b0, instr_ready}, 8'h00);
    rst_n = 1'b1;
    #1;
    check("rst_ready",  {7'b0, instr_ready}, 8'h01);
    check("rst_done",   {7'b0, done}, 8'h00);
    check("rst_gr",     {7'b0, flg_gr}, 8'h00);
    check("rst_eq",     {7'b0, flg_eq}, 8'h00);
    check("rst_op",     {5'b0, alu_opcode}, 8'h00);
    check("rst_a",      alu_a, 8'h00);
    check("rst_b",      alu_b, 8'h00);
    rf_check("rst_r7", 3'd7, 8'h00);

    // Build constants from r0 = 0.
    issue("nand_r7", 3'b001, 3'd7, 3'd0, 3'd0, 1'b0, 8'h00);
    rf_check("r7_ff", 3'd7, 8'hFF);
    check("nand_gr_keep", {7'b0, flg_gr}, 8'h00);
    issue("add_r6", 3'b110, 3'd6, 3'd7, 3'd7, 1'b0, 8'h00);
    rf_check("r6_fe_wrap", 3'd6, 8'hFE);
    issue("sub_r5", 3'b111, 3'd5, 3'd7, 3'd6, 1'b0, 8'h00);
    check("sub_r5_op", {5'b0, exec_op}, 8'h07);
    check("sub_r5_a",  exec_a, 8'hFF);
    check("sub_r5_b",  exec_b, 8'hFE);
    rf_check("r5_01", 3'd5, 8'h01);
    check("sub_r5_gr", {7'b0, flg_gr}, 8'h01);
    check("sub_r5_eq", {7'b0, flg_eq}, 8'h00);
    issue("add_r2a", 3'b110, 3'd2, 3'd5, 3'd5, 1'b0, 8'h00);
    issue("add_r2b", 3'b110, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00);
    issue("add_r2c", 3'b110, 3'd2, 3'd2, 3'd2, 1'b0, 8'h00);
    rf_check("r2_08", 3'd2, 8'h08);
    issue("add_r1", 3'b110, 3'd1, 3'd2, 3'd2, 1'b0, 8'h00);
    rf_check("r1_10", 3'd1, 8'h10);

    // Compares with rd = 0.
    issue("cmp_22_a", 3'b111, 3'd0, 3'd2, 3'd2, 1'b0, 8'h00);
    check("cmp_22_a_gr", {7'b0, flg_gr}, 8'h00);
    check("cmp_22_a_eq", {7'b0, flg_eq}, 8'h01);
    issue("cmp_12", 3'b111, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00);
    check("cmp_12_a", exec_a, 8'h10);
    check("cmp_12_b", exec_b, 8'h08);
    check("cmp_12_gr", {7'b0, flg_gr}, 8'h01);
    check("cmp_12_eq", {7'b0, flg_eq}, 8'h00);
    rf_check("r0_zero", 3'd0, 8'h00);
    check("alu_a_hold", alu_a, 8'h10);
    check("alu_b_hold", alu_b, 8'h08);
    issue("xor_r3", 3'b100, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
    rf_check("r3_18", 3'd3, 8'h18);
    check("xor_gr_keep", {7'b0, flg_gr}, 8'h01);
    check("xor_eq_keep", {7'b0, flg_eq}, 8'h00);
    issue("cmp_22_b", 3'b111, 3'd0, 3'd2, 3'd2, 1'b0, 8'h00);
    check("cmp_22_b_gr", {7'b0, flg_gr}, 8'h00);
    check("cmp_22_b_eq", {7'b0, flg_eq}, 8'h01);
    issue("cmp_21", 3'b111, 3'd0, 3'd2, 3'd1, 1'b0, 8'h00);
    check("cmp_21_gr", {7'b0, flg_gr}, 8'h00);
    check("cmp_21_eq", {7'b0, flg_eq}, 8'h00);

    // Remaining logic opcodes.
    issue("and_r4", 3'b000, 3'd4, 3'd1, 3'd3, 1'b0, 8'h00);
    rf_check("r4_and", 3'd4, 8'h10);
    issue("or_r4", 3'b010, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00);
    rf_check("r4_or", 3'd4, 8'h18);
    issue("nor_r4", 3'b011, 3'd4, 3'd1, 3'd3, 1'b0, 8'h00);
    rf_check("r4_nor", 3'd4, 8'hE7);
    issue("xnor_r4", 3'b101, 3'd4, 3'd1, 3'd3, 1'b0, 8'h00);
    rf_check("r4_xnor", 3'd4, 8'hF7);
    issue("nor_r4b", 3'b011, 3'd4, 3'd1, 3'd2, 1'b0, 8'h00);
    rf_check("r4_e7", 3'd4, 8'hE7);

    // Immediate select.
    issue("imm_r5", 3'b110, 3'd5, 3'd1, 3'd2, 1'b1, 8'h7F);
`ifdef ALU_SEQ_IMM_EN
    rf_check("r5_imm", 3'd5, 8'h8F);
`else
    rf_check("r5_imm", 3'd5, 8'h18);
`endif

    // Valid held high, a different instruction every cycle: only the ones
    // presented while ready is high (every third cycle) add r1 into r4.
    acc_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      instr_op     = 3'b110;
      instr_rd     = 3'd4;
      instr_ra     = 3'd4;
      instr_rb     = (i % 3 == 0) ? 3'd1 : 3'd7;
      instr_imm_en = 1'b0;
      instr_valid  = 1'b1;
      #1;
      if (instr_ready) acc_cnt++;
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    instr_valid = 1'b0;
    check("b2b_accepts", acc_cnt[7:0], 8'd3);
    check("b2b_dones",   done_cnt[7:0], 8'd3);
    rf_check("b2b_r4", 3'd4, 8'h17);
    check("b2b_ready_end", {7'b0, instr_ready}, 8'h01);

    // Reset during EXEC cancels writeback and done.
    instr_op    = 3'b110;
    instr_rd    = 3'd4;
    instr_ra    = 3'd1;
    instr_rb    = 3'd1;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("mid_exec_ready", {7'b0, instr_ready}, 8'h00);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {7'b0, instr_ready}, 8'h00);
    @(posedge clk); #1;
    check("mid_rst_done", {7'b0, done}, 8'h00);
    check("mid_rst_ready2", {7'b0, instr_ready}, 8'h00);
    check("mid_rst_a", alu_a, 8'h00);
    rf_check("mid_rst_r4", 3'd4, 8'h00);
    rf_check("mid_rst_r1", 3'd1, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", {7'b0, instr_ready}, 8'h01);
    check("post_rst_done", {7'b0, done}, 8'h00);
    rf_check("post_rst_r4", 3'd4, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
